// File: rtl/uart_receiver_if.sv
// -----------------------------------------------------------------------------
// uart_receiver_if
// Byte-side bundle of the UART receive stage. The receiver is the master: it
// produces bytes and status pulses. The consumer (for example the memory-mapped
// IO block) is the slave: it returns DataOutReady to pop a byte.
//   DataOut       received byte, stable while DataOutValid=1
//   DataOutValid  a byte is available
//   DataOutReady  consumer accepts the byte
//   FramingError  one-cycle pulse, stop bit sampled low
//   Overrun       one-cycle pulse, good frame dropped because a byte was pending
//   ParityError   one-cycle pulse, even-parity check failed
//                 (present only when UART_RX_PARITY_EN is defined)
// -----------------------------------------------------------------------------
interface uart_receiver_if;
  logic [7:0] DataOut;
  logic       DataOutValid;
  logic       DataOutReady;
  logic       FramingError;
  logic       Overrun;
`ifdef UART_RX_PARITY_EN
  logic       ParityError;

  modport master (output DataOut, DataOutValid, FramingError, Overrun, ParityError,
                  input  DataOutReady);
  modport slave  (input  DataOut, DataOutValid, FramingError, Overrun, ParityError,
                  output DataOutReady);
`else
  modport master (output DataOut, DataOutValid, FramingError, Overrun,
                  input  DataOutReady);
  modport slave  (input  DataOut, DataOutValid, FramingError, Overrun,
                  output DataOutReady);
`endif
endinterface

// File: rtl/uart_receiver.sv
// -----------------------------------------------------------------------------
// uart_receiver
// Serial-to-parallel UART receive stage. Recovers 8N1 frames from SIn and
// presents each byte on a ready/valid port.
// Optional feature macro: UART_RX_PARITY_EN. When defined, the receiver
// expects one even-parity bit between the data bits and the stop bit, and
// drives ParityError on the interface.
// Ports:
//   Clock    in   system clock, rising-edge active
//   Reset_n  in   asynchronous active-low reset
//   SIn      in   serial line, idle high, asynchronous to Clock
//   rx_o     uart_receiver_if.master: DataOut, DataOutValid, DataOutReady,
//            FramingError, Overrun (and ParityError when enabled)
// Parameters:
//   ClockFreq  system clock frequency in Hz
//   BaudRate   serial bit rate
// -----------------------------------------------------------------------------
module uart_receiver #(
  parameter int ClockFreq = 50_000_000,
  parameter int BaudRate  = 115_200
) (
  input  logic            Clock,
  input  logic            Reset_n,
  input  logic            SIn,
  uart_receiver_if.master rx_o
);

  localparam int SymbolTicks = ClockFreq / BaudRate;
  localparam int SampleTicks = SymbolTicks / 2;
  localparam int CntW        = (SymbolTicks > 1) ? $clog2(SymbolTicks) : 1;
  localparam logic [CntW-1:0] SymbolLast = CntW'(SymbolTicks - 1);
  localparam logic [CntW-1:0] SampleLast = CntW'(SampleTicks - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_RX_PARITY_EN
    PARITY,
`endif
    STOP
  } state_e;

  state_e          state_q;
  logic [1:0]      sync_q;
  logic [CntW-1:0] cnt_q;
  logic [2:0]      bit_idx_q;
  logic [7:0]      shift_q;
  logic [7:0]      data_q;
  logic            valid_q;
  logic            ferr_q;
  logic            ovr_q;
  logic            wait_high_q;

  logic rx_s;
  logic sym_wrap_d;
  logic pop_d;
  logic par_bad_d;

  // All decisions use the second synchronizer flop; its latency is not
  // compensated, so every sample point simply lands two cycles later.
  assign rx_s       = sync_q[1];
  assign sym_wrap_d = (cnt_q == SymbolLast);
  assign pop_d      = valid_q & rx_o.DataOutReady;

`ifdef UART_RX_PARITY_EN
  logic par_bit_q;
  logic perr_q;
  // Even parity: data bits plus parity bit must XOR to zero.
  assign par_bad_d        = ^{shift_q, par_bit_q};
  assign rx_o.ParityError = perr_q;
`else
  assign par_bad_d = 1'b0;
`endif

  assign rx_o.DataOut      = data_q;
  assign rx_o.DataOutValid = valid_q;
  assign rx_o.FramingError = ferr_q;
  assign rx_o.Overrun      = ovr_q;

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q     <= IDLE;
      sync_q      <= 2'b11;
      cnt_q       <= '0;
      bit_idx_q   <= '0;
      shift_q     <= '0;
      data_q      <= '0;
      valid_q     <= 1'b0;
      ferr_q      <= 1'b0;
      ovr_q       <= 1'b0;
      wait_high_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bit_q   <= 1'b0;
      perr_q      <= 1'b0;
`endif
    end else begin
      sync_q <= {sync_q[0], SIn};
      ferr_q <= 1'b0;
      ovr_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      perr_q <= 1'b0;
`endif
      // A pop clears valid unless a new byte loads in the same cycle below.
      if (pop_d) valid_q <= 1'b0;

      case (state_q)
        IDLE: begin
          cnt_q <= '0;
          // After a framing error the line must return high before we arm
          // again, so a held-low break reports only one error.
          if (wait_high_q) begin
            if (rx_s) wait_high_q <= 1'b0;
          end else if (!rx_s) begin
            state_q <= START;
          end
        end

        START: begin
          if (cnt_q == SampleLast) begin
            cnt_q     <= '0;
            bit_idx_q <= '0;
            state_q   <= rx_s ? IDLE : DATA;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end

        DATA: begin
          if (sym_wrap_d) begin
            cnt_q              <= '0;
            shift_q[bit_idx_q] <= rx_s;
            bit_idx_q          <= bit_idx_q + 1'b1;
            if (bit_idx_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
              state_q <= PARITY;
`else
              state_q <= STOP;
`endif
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end

`ifdef UART_RX_PARITY_EN
        PARITY: begin
          if (sym_wrap_d) begin
            cnt_q     <= '0;
            par_bit_q <= rx_s;
            state_q   <= STOP;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
`endif

        STOP: begin
          if (sym_wrap_d) begin
            cnt_q   <= '0;
            state_q <= IDLE;
`ifdef UART_RX_PARITY_EN
            if (par_bad_d) perr_q <= 1'b1;
`endif
            if (!rx_s) begin
              ferr_q      <= 1'b1;
              wait_high_q <= 1'b1;
            end else if (!par_bad_d) begin
              // A pop in this same cycle frees the slot, so it is not an overrun.
              if (!valid_q || pop_d) begin
                data_q  <= shift_q;
                valid_q <= 1'b1;
              end else begin
                ovr_q <= 1'b1;
              end
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end

        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_receiver.sv
`timescale 1ns/1ps
module tb_uart_receiver;

  localparam int ClkFreq = 1_000_000;
  localparam int Baud    = 100_000;
  localparam int BitT    = ClkFreq / Baud;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic sin   = 1'b1;

  uart_receiver_if rx_if ();

  uart_receiver #(.ClockFreq(ClkFreq), .BaudRate(Baud)) dut (
    .Clock   (clk),
    .Reset_n (rst_n),
    .SIn     (sin),
    .rx_o    (rx_if)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  // Model state: bytes the consumer must see, in order, and expected event counts.
  logic [7:0] exp_q[$];
  logic [7:0] popped_q[$];
  int exp_ferr = 0, exp_ovr = 0, exp_perr = 0;
  int obs_ferr = 0, obs_ovr = 0, obs_perr = 0;
  int cyc = 0, start_cyc = 0, rise_cyc = 0;
  logic prev_valid = 1'b0, prev_ferr = 1'b0, prev_ovr = 1'b0, prev_perr = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Cycle-by-cycle compare against the transaction model.
  always @(negedge clk) begin
    cyc++;
    if (rst_n) begin
      if (rx_if.FramingError) begin
        chk("ferr_single_cycle", 32'(prev_ferr), 32'd0);
        obs_ferr++;
      end
      if (rx_if.Overrun) begin
        chk("ovr_single_cycle", 32'(prev_ovr), 32'd0);
        obs_ovr++;
      end
`ifdef UART_RX_PARITY_EN
      if (rx_if.ParityError) begin
        chk("perr_single_cycle", 32'(prev_perr), 32'd0);
        obs_perr++;
      end
      prev_perr = rx_if.ParityError;
`endif
      if (rx_if.DataOutValid) begin
        if (!prev_valid) rise_cyc = cyc;
        chk("valid_has_model_byte", 32'(rx_if.DataOutValid), 32'(exp_q.size() != 0));
        if (exp_q.size() != 0) begin
          chk("data_vs_model", 32'(rx_if.DataOut), 32'(exp_q[0]));
          if (rx_if.DataOutReady) begin
            popped_q.push_back(exp_q[0]);
            void'(exp_q.pop_front());
          end
        end
      end
      prev_valid = rx_if.DataOutValid;
      prev_ferr  = rx_if.FramingError;
      prev_ovr   = rx_if.Overrun;
    end else begin
      prev_valid = 1'b0;
      prev_ferr  = 1'b0;
      prev_ovr   = 1'b0;
      prev_perr  = 1'b0;
    end
  end

  task automatic model_frame(input logic [7:0] b, input logic stop_v, input logic par_v);
    logic par_bad;
    par_bad = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_bad = ^{b, par_v};
    if (par_bad) exp_perr++;
`endif
    if (!stop_v) exp_ferr++;
    else if (!par_bad && par_v !== 1'bz) begin
      if (exp_q.size() != 0) exp_ovr++;
      else exp_q.push_back(b);
    end
  endtask

  task automatic send_bit(input logic v);
    @(posedge clk); #1 sin = v;
    repeat (BitT - 1) @(posedge clk);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_v, input logic par_v);
    @(posedge clk); #1 sin = 1'b0; start_cyc = cyc;
    repeat (BitT - 1) @(posedge clk);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
`ifdef UART_RX_PARITY_EN
    send_bit(par_v);
`endif
    model_frame(b, stop_v, par_v);
    send_bit(stop_v);
  endtask

  task automatic wait_valid(input string name, input int budget);
    int n;
    n = 0;
    while (!rx_if.DataOutValid && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk(name, 32'(rx_if.DataOutValid), 32'd1);
  endtask

  task automatic pop();
    @(posedge clk); #1 rx_if.DataOutReady = 1'b1;
    @(posedge clk); #1 rx_if.DataOutReady = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  int base_ferr, base_ovr, base_perr;

  initial begin
    rx_if.DataOutReady = 1'b0;
    idle(3);
    // Reset state
    chk("rst_valid", 32'(rx_if.DataOutValid), 32'd0);
    chk("rst_data",  32'(rx_if.DataOut),      32'h00);
    chk("rst_ferr",  32'(rx_if.FramingError), 32'd0);
    chk("rst_ovr",   32'(rx_if.Overrun),      32'd0);
    rst_n = 1'b1;
    idle(2 * BitT);

    // 1: single byte, held until popped
    send_frame(8'hA5, 1'b1, 1'b0);
    wait_valid("a5_valid", 3 * BitT);
    chk("a5_data", 32'(rx_if.DataOut), 32'hA5);
    chk("a5_latency_in_window", 32'((rise_cyc - start_cyc) >= 95 && (rise_cyc - start_cyc) <= 101), 32'd1);
    idle(50);
    chk("a5_held_valid", 32'(rx_if.DataOutValid), 32'd1);
    chk("a5_held_data",  32'(rx_if.DataOut),      32'hA5);
    pop();
    chk("a5_popped", 32'(rx_if.DataOutValid), 32'd0);

    // 2: back-to-back frames with immediate pops
    popped_q.delete();
    base_ferr = obs_ferr; base_ovr = obs_ovr;
    rx_if.DataOutReady = 1'b1;
    send_frame(8'h55, 1'b1, 1'b0);
    send_frame(8'hAA, 1'b1, 1'b0);
    idle(3 * BitT);
    rx_if.DataOutReady = 1'b0;
    chk("b2b_count", 32'(popped_q.size()), 32'd2);
    if (popped_q.size() == 2) begin
      chk("b2b_first",  32'(popped_q[0]), 32'h55);
      chk("b2b_second", 32'(popped_q[1]), 32'hAA);
    end
    chk("b2b_no_ferr", 32'(obs_ferr - base_ferr), 32'd0);
    chk("b2b_no_ovr",  32'(obs_ovr - base_ovr),   32'd0);

    // 3: framing error followed by a long break, then recovery
    base_ferr = obs_ferr;
    send_frame(8'h3C, 1'b0, 1'b0);
    idle(30 * BitT);
    chk("break_one_ferr", 32'(obs_ferr - base_ferr), 32'd1);
    chk("break_ferr_model", 32'(obs_ferr), 32'(exp_ferr));
    chk("break_no_valid", 32'(rx_if.DataOutValid), 32'd0);
    sin = 1'b1;
    idle(3 * BitT);
    send_frame(8'h01, 1'b1, 1'b0);
    wait_valid("recover_valid", 3 * BitT);
    chk("recover_data", 32'(rx_if.DataOut), 32'h01);
    pop();

    // 4: overrun keeps the first byte
    base_ovr = obs_ovr;
    send_frame(8'h11, 1'b1, 1'b0);
    wait_valid("ovr_first_valid", 3 * BitT);
    send_frame(8'h22, 1'b1, 1'b0);
    idle(2 * BitT);
    chk("ovr_one_pulse", 32'(obs_ovr - base_ovr), 32'd1);
    chk("ovr_model", 32'(obs_ovr), 32'(exp_ovr));
    chk("ovr_data_kept", 32'(rx_if.DataOut), 32'h11);
    pop();
    chk("ovr_popped", 32'(rx_if.DataOutValid), 32'd0);

    // 5: glitch while idle, with ready asserted and nothing to pop
    base_ferr = obs_ferr;
    rx_if.DataOutReady = 1'b1;
    @(posedge clk); #1 sin = 1'b0;
    repeat (3) @(posedge clk);
    #1 sin = 1'b1;
    idle(3 * BitT);
    rx_if.DataOutReady = 1'b0;
    chk("glitch_no_valid", 32'(rx_if.DataOutValid), 32'd0);
    chk("glitch_no_ferr",  32'(obs_ferr - base_ferr), 32'd0);

    // 6: reset mid-frame with a byte pending
    send_frame(8'h5A, 1'b1, 1'b0);
    wait_valid("pre_rst_valid", 3 * BitT);
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(1'b0);
    @(posedge clk); #1 sin = 1'b1;
    idle(4);
    #2 rst_n = 1'b0;
    #1;
    exp_q.delete();
    chk("midrst_valid", 32'(rx_if.DataOutValid), 32'd0);
    chk("midrst_data",  32'(rx_if.DataOut),      32'h00);
    chk("midrst_ferr",  32'(rx_if.FramingError), 32'd0);
    chk("midrst_ovr",   32'(rx_if.Overrun),      32'd0);
    idle(3);
    rst_n = 1'b1;
    idle(2 * BitT);
    send_frame(8'h0F, 1'b1, 1'b0);
    wait_valid("post_rst_valid", 3 * BitT);
    chk("post_rst_data", 32'(rx_if.DataOut), 32'h0F);
    pop();

`ifdef UART_RX_PARITY_EN
    // 7: parity good and parity bad
    base_perr = obs_perr;
    send_frame(8'h07, 1'b1, 1'b1);
    wait_valid("par_ok_valid", 3 * BitT);
    chk("par_ok_data", 32'(rx_if.DataOut), 32'h07);
    pop();
    send_frame(8'h07, 1'b1, 1'b0);
    idle(3 * BitT);
    chk("par_bad_pulse", 32'(obs_perr - base_perr), 32'd1);
    chk("par_bad_model", 32'(obs_perr), 32'(exp_perr));
    chk("par_bad_no_valid", 32'(rx_if.DataOutValid), 32'd0);
`else
    base_perr = 0;
`endif

    idle(BitT);
    chk("final_ferr_model", 32'(obs_ferr), 32'(exp_ferr));
    chk("final_ovr_model",  32'(obs_ovr),  32'(exp_ovr));
    chk("final_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #500_000;
    $display("FAIL watchdog: actual timeout required completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/uart_receiver.md
Name: uart_receiver

Overview:
- Serial-to-parallel UART receive stage: recovers 8N1 frames from the FPGA serial input line and presents each byte on a ready/valid port.
- Sits directly upstream of the memory-mapped IO interface, which polls its valid flag and pops bytes on a receive-data read.
- Stands alone so the receive path can be verified and reused without the transmit half.

Parameters:
- ClockFreq, 50_000_000, system clock frequency in Hz.
- BaudRate, 115_200, serial bit rate. SymbolTicks = ClockFreq/BaudRate (integer divide), SampleTicks = SymbolTicks/2.

Ports:
- Clock  in  1  system clock; all state changes on the rising edge.
- Reset_n  in  1  asynchronous, active-low reset.
- SIn  in  1  serial line (idle high), asynchronous to Clock.
- DataOut  out  8  received byte; stable while DataOutValid=1.
- DataOutValid  out  1  byte available.
- DataOutReady  in  1  consumer accepts the byte.
- FramingError  out  1  one-cycle pulse when the stop bit is sampled low.
- Overrun  out  1  one-cycle pulse when a good frame completes while DataOutValid=1.

Behaviour:
- Reset (Reset_n=0, asynchronous): state IDLE, counters 0, synchronizer flops 1, DataOut=8'h00, DataOutValid=0, FramingError=0, Overrun=0. Reset mid-frame abandons the frame. No byte is produced.
- Synchronizer: SIn passes through 2 flops; all decisions use the second flop (rx_s). The 2-cycle latency is uniform and is not compensated.
- Bit counter ticks every Clock. Sample points fall at SampleTicks into the start bit, then every SymbolTicks after that.
- IDLE: rx_s=0 -> START, counter cleared.
- START: at SampleTicks, rx_s=0 -> DATA, bit index 0. rx_s=1 -> false start, back to IDLE, no outputs.
- DATA: each SymbolTicks, shift rx_s into bit[index], LSB first. After bit 7 -> STOP.
- STOP: sample at SymbolTicks.
  - rx_s=1 and DataOutValid=0: DataOut <= shift register, DataOutValid <= 1 next cycle.
  - rx_s=1 and DataOutValid=1: new byte dropped, DataOut unchanged, Overrun pulses 1 cycle.
  - rx_s=0: byte discarded, FramingError pulses 1 cycle.
  - All three cases then go to IDLE. After a framing error, IDLE waits for rx_s=1 before arming again, so a held-low line (break) gives exactly one error.
- Handshake:
  - DataOutValid falls the cycle after a cycle with DataOutValid=1 and DataOutReady=1.
  - DataOutReady with DataOutValid=0 is ignored.
  - A frame that completes in the same cycle as a pop is not an overrun: the pop takes priority, and the new byte loads with DataOutValid kept at 1.
- Back-to-back frames: a start bit immediately after the stop sample is caught, because IDLE is entered in the cycle after the stop sample.
- Width rules: counters are sized to hold SymbolTicks-1. Compare to SymbolTicks-1 for wrap, and to SampleTicks-1 for the start check.

Optional Feature:
- Macro UART_RX_PARITY_EN.
- Defined:
  - Adds a PARITY state between DATA and STOP that samples one even-parity bit.
  - Adds output ParityError (1 bit, reset 0). It pulses 1 cycle at the stop sample if the XOR of the 8 data bits and the parity bit is 1.
  - A byte with a parity error is discarded and does not raise DataOutValid.
  - Frame length becomes 11 bits.
- Undefined: no PARITY state and no ParityError port. The frame is 10 bits (8N1).

Test Plan:
- ClockFreq=1_000_000, BaudRate=100_000 (10 ticks/bit); send 8'hA5 8N1, DataOutReady=0 -> DataOutValid rises about 100 cycles after the start edge, DataOut=8'hA5, held until DataOutReady=1 for 1 cycle, then DataOutValid=0.
- Send 8'h55 then 8'hAA back-to-back, popping each when valid -> two handshakes with DataOut 8'h55 then 8'hAA; FramingError=0 and Overrun=0 throughout.
- Send 8'h3C with stop bit forced low, line then held low for 30 bit times -> exactly one FramingError pulse, DataOutValid stays 0; after line returns high, 8'h01 is received correctly.
- Send 8'h11 without popping, then 8'h22 -> Overrun pulses once, DataOut remains 8'h11; pop then yields DataOutValid=0.
- Glitch SIn low for 3 cycles while idle -> false start rejected, no outputs. Assert Reset_n=0 mid-frame during bit 4 of 8'hF0 -> all outputs 0 immediately; the next full frame 8'h0F is received correctly.
- With UART_RX_PARITY_EN: 8'h07 with parity bit 1 -> DataOut=8'h07. Same byte with parity bit 0 -> ParityError pulse, DataOutValid stays 0.
